blit_mem_ctl: RTL



---
 rtl/blit_mem_ctl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/blit_mem_ctl.sv
// blit_mem_ctl: the blitter's memory-cycle controller.
// Requests from the blitter address/data units go into a small circular
// queue. The head entry is presented on the shared bus while the bus is
// granted. Reads that have been accepted are counted until their data
// strobes return.
//
// Handshake (req side): a request transfers on a rising edge where
// req_valid and req_ready are both high. req_ready depends only on the
// registered occupancy, never on req_valid. A request offered while the
// queue is full is not taken; the blitter keeps req_valid and the fields
// stable until it sees req_ready.
module blit_mem_ctl #(
  parameter int ADDR_W = 24,
  parameter int QDEPTH = 2,
  parameter int RD_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_width,
  input  logic              req_justify,
  output logic              req_ready,
  input  logic              bus_grant,
  input  logic              ack,
  input  logic              rdack,
  output logic [ADDR_W-1:0] addr_out,
  output logic [ADDR_W-1:0] addr_oe,
  output logic [3:0]        width_out,
  output logic [3:0]        width_oe,
  output logic              justify_out,
  output logic              justify_oe,
  output logic              read_out,
  output logic              read_oe,
  output logic              mreq_out,
  output logic              mreq_oe,
  output logic              active,
  output logic              wactive,
  output logic              memidle,
  output logic              blitack,
  output logic              memready,
  output logic              read_ack
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RD_W  = $clog2(RD_MAX + 1);

  // Queue storage: one entry is {write, addr, width, justify}
  logic [QDEPTH-1:0] q_write;
  logic [ADDR_W-1:0] q_addr    [QDEPTH];
  logic [3:0]        q_width   [QDEPTH];
  logic [QDEPTH-1:0] q_justify;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [RD_W-1:0]   rd_pend;

  logic              not_empty;
  logic              head_write;
  logic              head_blocked;
  logic              issue;
  logic              push;
  logic              pop;
  logic              rd_issue;

  // Head decode, issue decision and the combinational bus strobes
  always_comb begin
    not_empty    = (count != '0);
    head_write   = q_write[rd_ptr];
    // A read at the head waits while the read tracker is saturated;
    // a write at the head is never held back by outstanding reads.
    head_blocked = ~head_write & (rd_pend == RD_W'(RD_MAX));
    issue        = not_empty & ~head_blocked;
    req_ready    = (count < CNT_W'(QDEPTH));
    push         = req_valid & req_ready;
    blitack      = ack & bus_grant & issue;
    pop          = blitack;
    rd_issue     = pop & ~head_write;
    read_ack     = rdack & (rd_pend != '0);
    active       = not_empty | (rd_pend != '0);
    memidle      = ~active;
    memready     = blitack & active;
    wactive      = not_empty & head_write;
  end

  // Bus drivers: head fields are driven whenever granted, even with mreq low
  always_comb begin
    addr_out    = q_addr[rd_ptr];
    width_out   = q_width[rd_ptr];
    justify_out = q_justify[rd_ptr];
    read_out    = ~head_write;
    mreq_out    = issue;
    addr_oe     = {ADDR_W{bus_grant}};
    width_oe    = {4{bus_grant}};
    justify_oe  = bus_grant;
    read_oe     = bus_grant;
    mreq_oe     = bus_grant;
  end

  // Queue payload write; contents need no reset because count gates use
  always_ff @(posedge clk) begin
    if (push) begin
      q_write[wr_ptr]   <= req_write;
      q_addr[wr_ptr]    <= req_addr;
      q_width[wr_ptr]   <= req_width;
      q_justify[wr_ptr] <= req_justify;
    end
  end

  // Pointers, occupancy and outstanding-read counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_pend <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A read leaving the queue and a returning strobe cancel out
      case ({rd_issue, read_ack})
        2'b10:   rd_pend <= rd_pend + RD_W'(1);
        2'b01:   rd_pend <= rd_pend - RD_W'(1);
        default: rd_pend <= rd_pend;
      endcase
    end
  end

endmodule
